shift_rotate_sequencer: RTL and testbench

//  Multi-cycle sequencer for the shared shift datapath used in CORDIC/FP normalization.

---
 rtl/shift_rotate_sequencer.sv | 135 +++++++++++++
 tb/tb_shift_rotate_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_sequencer.sv
// shift_rotate_sequencer
// Sequential barrel shifter for a SWR-bit significand. It handles one shift-amount
// bit per cycle behind a start/ready/valid handshake. Left shifts are done by
// reversing the operand, shifting right, and reversing the result back.
module shift_rotate_sequencer #(
  parameter int SWR = 26,
  parameter int EWR = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [SWR-1:0] data_i,
  input  logic [EWR-1:0] shift_amt_i,
  input  logic           left_i,
  output logic           ready_o,
  output logic           valid_o,
  output logic [SWR-1:0] data_o,
  output logic           sticky_o
);

  localparam int CW = (EWR > 1) ? $clog2(EWR) : 1;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SHIFT,
    POST,
    DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [SWR-1:0] r_workReg;
  logic [EWR-1:0] r_amt;
  logic           r_left;
  logic           r_sticky;
  logic [CW-1:0]  r_stepCnt;

  logic [31:0]    w_shiftDist;
  logic [SWR-1:0] w_stepData;
  logic           w_stepSticky;
  logic           w_lastStep;

  // Mirror a vector end for end so that a right shift acts as a left shift.
  function automatic logic [SWR-1:0] rev(input logic [SWR-1:0] x);
    logic [SWR-1:0] y;
    for (int j = 0; j < SWR; j++) begin
      y[j] = x[SWR-1-j];
    end
    return y;
  endfunction

  // Step k shifts by 2^k. Bits that fall off the bottom feed the sticky flag.
  // A distance of SWR or more clears the word and drops every bit.
  always_comb begin
    w_shiftDist  = 32'd1 << r_stepCnt;
    w_stepData   = r_workReg >> w_shiftDist;
    w_stepSticky = |(r_workReg & ~({SWR{1'b1}} << w_shiftDist));
    w_lastStep   = (r_stepCnt == CW'(EWR - 1));
  end

  // State register. Reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and handshake outputs. A request is accepted only in IDLE.
  always_comb begin
    w_nextState = r_state;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) w_nextState = PRE;
      end
      PRE:   w_nextState = SHIFT;
      SHIFT: if (w_lastStep) w_nextState = POST;
      POST:  w_nextState = DONE;
      DONE: begin
        valid_o     = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath. It captures the operands, conditions them for the shift, steps
  // through the amount bits, and publishes the result. The outputs are written
  // only in POST, so they hold steady while the block is idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_workReg <= '0;
      r_amt     <= '0;
      r_left    <= 1'b0;
      r_sticky  <= 1'b0;
      r_stepCnt <= '0;
      data_o    <= '0;
      sticky_o  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_workReg <= data_i;
            r_amt     <= shift_amt_i;
            r_left    <= left_i;
            r_sticky  <= 1'b0;
          end
        end
        PRE: begin
          if (r_left) r_workReg <= rev(r_workReg);
          r_stepCnt <= '0;
        end
        SHIFT: begin
          if (r_amt[r_stepCnt]) begin
            r_workReg <= w_stepData;
            if (!r_left) r_sticky <= r_sticky | w_stepSticky;
          end
          r_stepCnt <= r_stepCnt + 1'b1;
        end
        POST: begin
          data_o   <= r_left ? rev(r_workReg) : r_workReg;
          sticky_o <= r_left ? 1'b0 : r_sticky;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Testbench for shift_rotate_sequencer. A behavioural model predicts the
// handshake and result on every cycle. Directed cases pin literal values.
module tb_shift_rotate_sequencer;

  localparam int SWR = 26;
  localparam int EWR = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start_i = 1'b0;
  logic [SWR-1:0] data_i = '0;
  logic [EWR-1:0] shift_amt_i = '0;
  logic           left_i = 1'b0;
  logic           ready_o;
  logic           valid_o;
  logic [SWR-1:0] data_o;
  logic           sticky_o;

  int nCompared = 0;
  int nMismatched = 0;

  shift_rotate_sequencer #(.SWR(SWR), .EWR(EWR)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .data_i(data_i),
    .shift_amt_i(shift_amt_i), .left_i(left_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .sticky_o(sticky_o)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Compare one value against its expectation and count the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result for a shift, written from the arithmetic definition.
  function automatic logic [SWR-1:0] refData(input logic [SWR-1:0] d, input int a, input logic l);
    logic [SWR-1:0] r;
    if (a >= SWR) r = '0;
    else if (l)   r = d << a;
    else          r = d >> a;
    return r;
  endfunction

  function automatic logic refSticky(input logic [SWR-1:0] d, input int a, input logic l);
    logic [SWR-1:0] mask;
    if (l) return 1'b0;
    if (a >= SWR) return |d;
    mask = (SWR'(1) << a) - SWR'(1);
    return |(d & mask);
  endfunction

  // Model state. An operation is accepted at an edge when the model is idle,
  // start is high and reset is not asserted. The result appears seven edges
  // later, with valid for one cycle.
  bit             seenReset = 0;
  bit             mBusy = 0;
  int             mAge = 0;
  logic [SWR-1:0] mPendData = '0;
  logic           mPendSticky = 1'b0;
  logic [SWR-1:0] mData = '0;
  logic           mSticky = 1'b0;

  // Advance the model on each rising edge using the inputs driven at the prior negedge.
  always @(posedge clk) begin
    if (!rst) begin
      seenReset = 1;
      mBusy     = 0;
      mAge      = 0;
      mData     = '0;
      mSticky   = 1'b0;
    end else if (!mBusy) begin
      if (start_i) begin
        mBusy       = 1;
        mAge        = 0;
        mPendData   = refData(data_i, int'(shift_amt_i), left_i);
        mPendSticky = refSticky(data_i, int'(shift_amt_i), left_i);
      end
    end else if (mAge == 7) begin
      mBusy = 0;
    end else begin
      mAge++;
      if (mAge == 7) begin
        mData   = mPendData;
        mSticky = mPendSticky;
      end
    end
  end

  // Check every output against the model on each falling edge.
  always @(negedge clk) begin
    if (seenReset) begin
      checkOutput("ready_o", 32'(ready_o), 32'(!mBusy));
      checkOutput("valid_o", 32'(valid_o), 32'(mBusy && mAge == 7));
      checkOutput("data_o", 32'(data_o), 32'(mData));
      checkOutput("sticky_o", 32'(sticky_o), 32'(mSticky));
    end
  end

  // Run one operation with literal expectations and check its latency.
  task automatic applyStimulus(input string name, input logic [SWR-1:0] d, input logic [EWR-1:0] a,
                               input logic l, input logic [SWR-1:0] expD, input logic expS);
    int lat;
    int guard;
    guard = 0;
    while (!ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({name, "_ready"}, 32'(ready_o), 32'd1);
    start_i = 1'b1; data_i = d; shift_amt_i = a; left_i = l;
    @(negedge clk);
    start_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'd8);
    checkOutput({name, "_data"}, 32'(data_o), 32'(expD));
    checkOutput({name, "_sticky"}, 32'(sticky_o), 32'(expS));
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    int lastPulse;
    int sawValid;

    // Reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 32'(ready_o), 32'd1);
    checkOutput("reset_valid", 32'(valid_o), 32'd0);
    checkOutput("reset_data", 32'(data_o), 32'd0);
    checkOutput("reset_sticky", 32'(sticky_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    applyStimulus("rsh4", 26'h00000F0, 5'd4, 1'b0, 26'h000000F, 1'b0);
    applyStimulus("rsh2loss", 26'h0000013, 5'd2, 1'b0, 26'h0000004, 1'b1);
    applyStimulus("lsh25", 26'h0000001, 5'd25, 1'b1, 26'h2000000, 1'b0);
    applyStimulus("lsh1", 26'h3FFFFFF, 5'd1, 1'b1, 26'h3FFFFFE, 1'b0);
    applyStimulus("rsh31", 26'h0000001, 5'd31, 1'b0, 26'h0000000, 1'b1);
    applyStimulus("lsh26", 26'h3FFFFFF, 5'd26, 1'b1, 26'h0000000, 1'b0);
    applyStimulus("rsh0", 26'h2A5A5A5, 5'd0, 1'b0, 26'h2A5A5A5, 1'b0);
    applyStimulus("lsh0", 26'h1234567, 5'd0, 1'b1, 26'h1234567, 1'b0);

    // Start held high with changing inputs: one accept every 9 cycles
    start_i = 1'b1;
    pulses = 0;
    lastPulse = 0;
    for (int i = 1; i <= 45; i++) begin
      data_i = SWR'($urandom);
      shift_amt_i = EWR'($urandom);
      left_i = 1'(($urandom));
      @(negedge clk);
      if (valid_o) begin
        pulses++;
        lastPulse = i;
      end
      if (i == 45) start_i = 1'b0;
    end
    checkOutput("held_pulses", 32'(pulses), 32'd5);
    checkOutput("held_last_pulse", 32'(lastPulse), 32'd44);
    @(negedge clk);

    // Reset three cycles after accept. Start with a result that is not zero
    // so that a cleared data_o shows the reset took effect.
    applyStimulus("pre_reset", 26'h0000F00, 5'd4, 1'b0, 26'h00000F0, 1'b0);
    start_i = 1'b1; data_i = 26'h3FFFFFF; shift_amt_i = 5'd3; left_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("mid_reset_ready", 32'(ready_o), 32'd1);
    checkOutput("mid_reset_valid", 32'(valid_o), 32'd0);
    checkOutput("mid_reset_data", 32'(data_o), 32'd0);
    sawValid = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid_o) sawValid = 1;
    end
    checkOutput("mid_reset_no_valid", 32'(sawValid), 32'd0);

    // Reset asserted in the same cycle as start is not an accept
    rst = 1'b0; start_i = 1'b1;
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    checkOutput("reset_beats_start", 32'(ready_o), 32'd1);
    @(negedge clk);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) != 0);
      start_i     = ($urandom_range(0, 2) == 0);
      data_i      = SWR'($urandom);
      shift_amt_i = EWR'($urandom);
      left_i      = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    start_i = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
